// File: rtl/i2s_pkg.sv
// i2s_pkg: constants shared by the I2S transmit controller and its tick generator.
//   SLOT_BITS / FRAME_BITS : bits per channel slot and BCK periods per stereo frame.
//   DEF_CLK_HZ / DEF_BCK_HZ: default system clock and bit-clock frequencies.
//   ST_*                   : controller state encoding.
package i2s_pkg;
    localparam int SLOT_BITS  = 16;
    localparam int FRAME_BITS = 2 * SLOT_BITS;

    localparam int DEF_CLK_HZ = 6000000;
    localparam int DEF_BCK_HZ = 1411200;

    typedef logic [FRAME_BITS-1:0] frame_t;   // {left, right}, left MSB at bit 31

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STOPPING = 2'd2;
endpackage

// File: rtl/frac_tick_gen.sv
// frac_tick_gen: fractional phase accumulator producing single-cycle ticks whose
// average rate is exactly TICK_HZ from a CLK_HZ clock (jitter at most one clk).
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   run   in  1 = accumulate; 0 = hold the accumulator at zero, no ticks
//   tick  out combinational tick, valid in the cycle the accumulator wraps
// Requires 2^ACC_W > CLK_HZ + TICK_HZ so the sum never overflows.
module frac_tick_gen
    import i2s_pkg::*;
#(
    parameter int CLK_HZ  = DEF_CLK_HZ,
    parameter int TICK_HZ = 2 * DEF_BCK_HZ,
    parameter int ACC_W   = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);
    localparam int SUM_W = ACC_W + 1;
    localparam logic [ACC_W:0] C_STEP = SUM_W'(TICK_HZ);
    localparam logic [ACC_W:0] C_MOD  = SUM_W'(CLK_HZ);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W:0]   w_sum;
    logic             w_wrap;
    logic [ACC_W-1:0] w_wrapped;

    assign w_sum     = {1'b0, r_acc} + C_STEP;
    assign w_wrap    = (w_sum >= C_MOD);
    // The wrapped value is below 2^ACC_W, so modular subtraction on the low bits is exact.
    assign w_wrapped = w_sum[ACC_W-1:0] - C_MOD[ACC_W-1:0];
    assign tick      = run && w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (!run) begin
            r_acc <= '0;
        end else if (w_wrap) begin
            r_acc <= w_wrapped;
        end else begin
            r_acc <= w_sum[ACC_W-1:0];
        end
    end
endmodule

// File: rtl/i2s_tx_ctrl.sv
// i2s_tx_ctrl: Philips-format I2S transmitter for a PCM510x DAC, 16-bit stereo.
//   clk, rst_n          system clock / asynchronous active-low reset
//   enable              1 = run, 0 = stop at end of current frame
//   s_valid, s_ready    sample handshake; s_ready = holding buffer empty
//   s_left, s_right     two's-complement samples
//   clr_underrun        clears the sticky underrun flag (a same-cycle set wins)
//   bck, lrck, din      I2S bit clock, word select (0 = left), serial data MSB first
//   frame_start         one-cycle pulse after each frame boundary that loads a frame
//   underrun            sticky: a boundary found the holding buffer empty
//   busy                controller not idle
module i2s_tx_ctrl
    import i2s_pkg::*;
#(
    parameter int CLK_HZ           = DEF_CLK_HZ,
    parameter int BCK_HZ           = DEF_BCK_HZ,
    parameter int ACC_W            = 24,
    parameter bit MUTE_ON_UNDERRUN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 s_valid,
    input  logic [SLOT_BITS-1:0] s_left,
    input  logic [SLOT_BITS-1:0] s_right,
    output logic                 s_ready,
    input  logic                 clr_underrun,
    output logic                 bck,
    output logic                 lrck,
    output logic                 din,
    output logic                 frame_start,
    output logic                 underrun,
    output logic                 busy
);
    localparam int K_W = $clog2(FRAME_BITS);
    localparam logic [K_W-1:0] K_LAST = K_W'(FRAME_BITS - 1);

    logic [1:0]     r_state;
    logic           r_bck, r_lrck, r_din, r_frame_start, r_underrun;
    logic [K_W-1:0] r_k;
    frame_t         r_frame;      // frame currently on the wire
    frame_t         r_buf;        // one-entry holding buffer
    logic           r_buf_full;
    frame_t         r_last;       // last sample taken from the buffer

    logic           w_tick, w_boundary, w_stop, w_load, w_xfer, w_start;
    logic [K_W-1:0] w_k_next, w_bit_idx;
    frame_t         w_next_frame;

    frac_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(2 * BCK_HZ),
        .ACC_W  (ACC_W)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (r_state != ST_IDLE),
        .tick (w_tick)
    );

    // A tick while bck is high is a falling edge; the one leaving k=31 is a boundary.
    assign w_boundary   = w_tick && r_bck && (r_k == K_LAST);
    assign w_stop       = w_boundary && (r_state == ST_STOPPING) && !enable;
    assign w_load       = w_boundary && !w_stop;
    assign w_xfer       = s_valid && !r_buf_full;
    assign w_start      = (r_state == ST_IDLE) && enable && r_buf_full;
    assign w_k_next     = r_k + 1'b1;
    // Period k+1 carries frame bit (31-k): the one-BCK Philips delay.
    assign w_bit_idx    = K_LAST - r_k;
    assign w_next_frame = r_buf_full ? r_buf : (MUTE_ON_UNDERRUN ? '0 : r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_bck         <= 1'b0;
            r_lrck        <= 1'b0;
            r_din         <= 1'b0;
            r_k           <= K_LAST;
            r_frame       <= '0;
            r_buf         <= '0;
            r_buf_full    <= 1'b0;
            r_last        <= '0;
            r_underrun    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_load;

            // Boundary consumption and a new transfer are mutually exclusive
            // because a transfer needs the buffer empty.
            if (w_load && r_buf_full) begin
                r_buf_full <= 1'b0;
            end else if (w_xfer) begin
                r_buf_full <= 1'b1;
                r_buf      <= {s_left, s_right};
            end

            if (w_load && !r_buf_full) begin
                r_underrun <= 1'b1;
            end else if (clr_underrun) begin
                r_underrun <= 1'b0;
            end

            case (r_state)
                ST_IDLE:     if (w_start) r_state <= ST_RUN;
                ST_RUN:      if (!enable) r_state <= ST_STOPPING;
                ST_STOPPING: begin
                    if (enable) begin
                        r_state <= ST_RUN;
                    end else if (w_boundary) begin
                        r_state <= ST_IDLE;
                    end
                end
                default:     r_state <= ST_IDLE;
            endcase

            if (w_stop) begin
                // Park with the next first tick rising and the first fall a boundary.
                r_bck   <= 1'b0;
                r_lrck  <= 1'b0;
                r_din   <= 1'b0;
                r_k     <= K_LAST;
                r_frame <= '0;
            end else if (w_tick) begin
                r_bck <= ~r_bck;
                if (r_bck) begin
                    r_k    <= w_k_next;
                    r_lrck <= w_k_next[K_W-1];
                    if (w_boundary) begin
                        r_din   <= r_frame[0];   // right LSB of the frame just sent
                        r_frame <= w_next_frame;
                        if (r_buf_full) begin
                            r_last <= r_buf;
                        end
                    end else begin
                        r_din <= r_frame[w_bit_idx];
                    end
                end
            end
        end
    end

    assign s_ready     = ~r_buf_full;
    assign bck         = r_bck;
    assign lrck        = r_lrck;
    assign din         = r_din;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;
    assign busy        = (r_state != ST_IDLE);
endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Directed testbench for i2s_tx_ctrl with a frame scoreboard. A second instance
// built with MUTE_ON_UNDERRUN=0 shares all inputs to cover the repeat-last behaviour.
module tb_i2s_tx_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, enable, s_valid, clr_underrun;
    logic [15:0] s_left, s_right;
    logic        s_ready, bck, lrck, din, frame_start, underrun, busy;
    logic        s_ready_rep, bck_rep, lrck_rep, din_rep, frame_start_rep, underrun_rep, busy_rep;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q_main[$];
    logic [31:0] q_rep[$];
    bit          sb_on = 1'b1;

    always #5 clk = ~clk;

    i2s_tx_ctrl dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .s_valid(s_valid),
        .s_left(s_left), .s_right(s_right), .s_ready(s_ready),
        .clr_underrun(clr_underrun), .bck(bck), .lrck(lrck), .din(din),
        .frame_start(frame_start), .underrun(underrun), .busy(busy)
    );

    i2s_tx_ctrl #(.MUTE_ON_UNDERRUN(1'b0)) dut_rep (
        .clk(clk), .rst_n(rst_n), .enable(enable), .s_valid(s_valid),
        .s_left(s_left), .s_right(s_right), .s_ready(s_ready_rep),
        .clr_underrun(clr_underrun), .bck(bck_rep), .lrck(lrck_rep), .din(din_rep),
        .frame_start(frame_start_rep), .underrun(underrun_rep), .busy(busy_rep)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // ---------------- frame monitor / scoreboard consumer ----------------
    int          fs_total = 0;
    int          rc = 0;
    int          nbits = 0;
    bit          in_frame = 0, pending = 0, prev_bck = 0;
    logic [31:0] w_m = '0, w_r = '0, e_m = '0, e_r = '0, pe_m = '0, pe_r = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 0; pending = 0; prev_bck = 0; rc = 0; nbits = 0;
        end else begin
            if (!busy) begin
                in_frame = 0; pending = 0;
            end
            if (frame_start) begin
                fs_total++;
                if (in_frame) chk("bck_per_frame", 32'(rc), 32'd32);
                pending = in_frame && (nbits == 31) && sb_on;
                pe_m = e_m; pe_r = e_r;
                if (sb_on) begin
                    chk("sb_has_entry", 32'(q_main.size() > 0 && q_rep.size() > 0), 32'd1);
                    if (q_main.size() > 0) e_m = q_main.pop_front(); else e_m = 'x;
                    if (q_rep.size() > 0)  e_r = q_rep.pop_front();  else e_r = 'x;
                end
                in_frame = 1; rc = 0; nbits = 0;
            end
            if (bck && !prev_bck && in_frame) begin
                rc++;
                chk("lrck_period", 32'(lrck), 32'(rc >= 17));
                if (rc == 1 && pending) begin
                    w_m = {w_m[30:0], din};
                    w_r = {w_r[30:0], din_rep};
                    chk("frame_mute", w_m, pe_m);
                    chk("frame_repeat", w_r, pe_r);
                    pending = 0;
                end else if (rc >= 2 && rc <= 32) begin
                    w_m = {w_m[30:0], din};
                    w_r = {w_r[30:0], din_rep};
                    nbits++;
                end
            end
            prev_bck = bck;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [15:0] l, input logic [15:0] r);
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (s_ready) begin
                s_left = l; s_right = r; s_valid = 1'b1;
                q_main.push_back({l, r});
                q_rep.push_back({l, r});
                @(negedge clk);
                s_valid = 1'b0;
                done = 1;
            end
        end
        chk("send_accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_fs(input int target, input int budget);
        int i = 0;
        while (fs_total < target && i < budget) begin
            @(posedge clk);
            i++;
        end
        chk("frame_start_seen", 32'(fs_total >= target), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("busy_fell", 32'(busy), 32'd0);
    endtask

    task automatic count_falls(input int n, output int got);
        bit pb;
        got = 0;
        pb = bck;
        for (int i = 0; i < 1000 && got < n; i++) begin
            @(negedge clk);
            if (pb && !bck) got++;
            pb = bck;
        end
    endtask

    int          fs0, toggles, frames, falls, falls2, xfers, nfs;
    bit          pb, took;
    logic [15:0] pay;

    initial begin
        rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; clr_underrun = 1'b0;
        s_left = '0; s_right = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bck", 32'(bck), 32'd0);
        chk("rst_lrck", 32'(lrck), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rep", 32'({bck_rep, lrck_rep, din_rep, s_ready_rep, frame_start_rep, underrun_rep, busy_rep}),
            32'(7'b0001000));
        rst_n = 1'b1;

        // Idle with enable low: bck never rises
        toggles = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bck) toggles++;
        end
        chk("idle_bck_high_cycles", 32'(toggles), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Single frame A5C3/1234, followed by a second so its right LSB is emitted
        fs0 = fs_total;
        send(16'hA5C3, 16'h1234);
        enable = 1'b1;
        send(16'h8001, 16'h7FFE);
        wait_fs(fs0 + 2, 2000);
        enable = 1'b0;
        wait_idle(1000);
        chk("stop_ready", 32'(s_ready), 32'd1);
        chk("single_q_drained", 32'(q_main.size()), 32'd0);

        // Rate over 30000 clk: 30000*2822400/6e6 = 14112 ticks, 221 frame boundaries
        sb_on = 1'b0;
        send(16'h1111, 16'h2222);
        enable = 1'b1;
        for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
        chk("rate_started", 32'(busy), 32'd1);
        toggles = 0; frames = 0; pb = bck;
        repeat (30000) begin
            @(negedge clk);
            if (bck != pb) toggles++;
            pb = bck;
            if (frame_start) frames++;
        end
        chk_range("rate_ticks", toggles, 14111, 14113);
        chk_range("rate_frames", frames, 220, 222);
        chk("rate_underrun", 32'(underrun), 32'd1);
        enable = 1'b0;
        wait_idle(1000);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        chk("rate_underrun_cleared", 32'(underrun), 32'd0);
        q_main.delete();
        q_rep.delete();
        sb_on = 1'b1;

        // Underrun: one sample, then nothing; mute instance sends zeros, other repeats
        fs0 = fs_total;
        send(16'h1357, 16'h2468);
        q_main.push_back(32'h0); q_main.push_back(32'h0);
        q_rep.push_back({16'h1357, 16'h2468}); q_rep.push_back({16'h1357, 16'h2468});
        enable = 1'b1;
        wait_fs(fs0 + 1, 2000);
        chk("underrun_not_yet", 32'(underrun), 32'd0);
        wait_fs(fs0 + 2, 2000);
        chk("underrun_set", 32'(underrun), 32'd1);
        wait_fs(fs0 + 3, 2000);
        enable = 1'b0;
        wait_idle(1000);
        chk("underrun_sticky", 32'(underrun), 32'd1);
        chk("underrun_sticky_rep", 32'(underrun_rep), 32'd1);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        chk("underrun_cleared", 32'(underrun), 32'd0);

        // Back-pressure: s_valid held high, payload advances on every transfer
        xfers = 0; nfs = 0; pay = 16'h0100;
        @(negedge clk);
        s_left = pay; s_right = ~pay; s_valid = 1'b1; enable = 1'b1;
        took = s_ready;
        if (took) begin
            q_main.push_back({pay, ~pay}); q_rep.push_back({pay, ~pay}); xfers++;
        end
        for (int i = 0; i < 3000 && nfs < 6; i++) begin
            @(negedge clk);
            if (took) begin
                pay = pay + 16'd1;
                s_left = pay; s_right = ~pay;
            end
            if (frame_start) nfs++;
            if (took && xfers == 1) chk("bp_ready_drop", 32'(s_ready), 32'd0);
            took = s_ready;
            if (took) begin
                q_main.push_back({pay, ~pay}); q_rep.push_back({pay, ~pay}); xfers++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0; enable = 1'b0;
        chk("bp_frames", 32'(nfs), 32'd6);
        chk("bp_xfer_per_frame", 32'(xfers), 32'(nfs + 1));
        wait_idle(1000);
        chk("bp_buffer_held", 32'(s_ready), 32'd0);

        // Stop at k=7: frame runs to k=31, idle at the boundary (32 falls in total)
        fs0 = fs_total;
        enable = 1'b1;
        wait_fs(fs0 + 1, 2000);
        count_falls(7, falls);
        enable = 1'b0;
        falls2 = 0; pb = bck;
        for (int i = 0; i < 1000 && busy; i++) begin
            @(negedge clk);
            if (pb && !bck) falls2++;
            pb = bck;
        end
        chk("stop_k7_falls", 32'(falls + falls2), 32'd32);
        chk("stop_k7_busy", 32'(busy), 32'd0);
        chk("stop_k7_bck", 32'(bck), 32'd0);
        chk("stop_k7_q_drained", 32'(q_main.size()), 32'd0);

        // Asynchronous reset at k=20 (lrck=1, din = bit 12 of R 1234 = 1)
        fs0 = fs_total;
        send(16'hA5C3, 16'h1234);
        enable = 1'b1;
        wait_fs(fs0 + 1, 2000);
        count_falls(20, falls);
        chk("k20_reached", 32'(falls), 32'd20);
        chk("k20_lrck", 32'(lrck), 32'd1);
        chk("k20_din", 32'(din), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_bck", 32'(bck), 32'd0);
        chk("async_rst_lrck", 32'(lrck), 32'd0);
        chk("async_rst_din", 32'(din), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("final_q_empty", 32'(q_main.size() + q_rep.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
